// File: rtl/r121_serial_ctrl.sv
// r121_serial_ctrl: adds two WIDTH-bit operands two bits per cycle by driving
// an external 2-bit ripple adder and collecting its sum digits, LSB digit first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair; last result held on sum/cout_out
// RUN   | one 2-bit digit presented to the adder per cycle
// DONE  | result valid; held until the consumer takes it
module r121_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             A0,
    output logic             A1,
    output logic             B0,
    output logic             B1,
    output logic             Cin,
    input  logic             S0,
    input  logic             S1,
    input  logic             Cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout_out
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             running;

    // New digit enters at the top; after DIGITS shifts digit 0 sits in [1:0].
    generate
        if (WIDTH > 2) begin : g_wide
            assign sum_next = {S1, S0, sum[WIDTH-1:2]};
        end else begin : g_narrow
            assign sum_next = {S1, S0};
        end
    endgenerate

    // Sequencer: operand capture, per-digit shifting and result hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_shift  <= '0;
            b_shift  <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_shift <= op_a;
                        b_shift <= op_b;
                        carry   <= cin_in;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum     <= sum_next;
                    carry   <= Cout;
                    a_shift <= a_shift >> 2;
                    b_shift <= b_shift >> 2;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_out <= Cout;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and adder-facing outputs decode flops only; adder pins are quiet outside RUN.
    always_comb begin
        running   = (state == RUN);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        A0        = running & a_shift[0];
        A1        = running & a_shift[1];
        B0        = running & b_shift[0];
        B1        = running & b_shift[1];
        Cin       = running & carry;
    end

endmodule

// File: tb/tb_r121_serial_ctrl.sv
// Bench for r121_serial_ctrl (WIDTH=8): models the external 2-bit adder,
// runs directed corner cases and randomized traffic against a scoreboard.
module tb_r121_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin_in = 1'b0;
    logic         A0, A1, B0, B1, Cin;
    logic         S0, S1, Cout;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout_out;

    int vectors = 0;
    int errors  = 0;
    logic [W:0] sb[$];
    bit   rand_stall  = 1'b0;
    bit   ready_force = 1'b1;
    bit   held_valid  = 1'b0;
    logic [W:0] held;

    r121_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1), .Cin(Cin),
        .S0(S0), .S1(S1), .Cout(Cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout_out(cout_out)
    );

    // External 2-bit ripple adder.
    assign {Cout, S1, S0} = 3'({A1, A0}) + 3'({B1, B0}) + 3'(Cin);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one pair; expected result is pushed on the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op_a = a; op_b = b; cin_in = c; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back({1'b0, a} + {1'b0, b} + (W+1)'(c));
        #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin_in = 1'($urandom);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Consumer readiness: either forced or randomly stalling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_stall ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    // Monitor: pops and compares results, checks hold stability and quiet adder pins.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("done_adder_pins", 32'({A1, A0, B1, B0, Cin}), 32'd0);
                if (held_valid) chk("held_result", 32'({cout_out, sum}), 32'(held));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'({cout_out, sum}), 32'h1ff);
                    end else begin
                        chk("result", 32'({cout_out, sum}), 32'(sb.pop_front()));
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held = {cout_out, sum};
                end
            end else begin
                held_valid = 1'b0;
            end
            if (in_ready) chk("idle_adder_pins", 32'({A1, A0, B1, B0, Cin}), 32'd0);
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        logic [W-1:0] a, b;
        logic c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'({cout_out, sum}), 32'd0);
        chk("rst_adder_pins", 32'({A1, A0, B1, B0, Cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        // 0x00+0x00: latency of exactly four edges after acceptance
        send(8'h00, 8'h00, 1'b0);
        wait_valid(edges);
        chk("latency_edges", 32'(edges), 32'd4);

        // 0xFF+0x01: carry into digits 1..3 must be 1
        send(8'hFF, 8'h01, 1'b0);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk("cin_digit", 32'(Cin), (d == 0) ? 32'd0 : 32'd1);
        end
        wait_valid(edges);

        // 0xA5+0x5A+1 with consumer backpressure and new operands offered
        ready_force = 1'b0;
        send(8'hA5, 8'h5A, 1'b1);
        wait_valid(edges);
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; cin_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'({cout_out, sum}), 32'h100);
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        out_ready = 1'b1;
        send(8'h12, 8'h34, 1'b0);
        wait_valid(edges);

        // Reset at digit 2 aborts; next op 0x7F+0x80 must be correct
        send(8'h3C, 8'h4B, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_adder_pins", 32'({A1, A0, B1, B0, Cin}), 32'd0);
        chk("abort_sum", 32'({cout_out, sum}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        send(8'h7F, 8'h80, 1'b0);
        wait_valid(edges);
        @(negedge clk);

        // Randomized traffic with random consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(a, b, c);
        end

        edges = 0;
        while ((sb.size() != 0 || out_valid) && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/r121_serial_ctrl.md
R121_SERIAL_CTRL -- requirements
Module: r121_serial_ctrl

Interface
REQ-001: Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: in_valid  input  1  operand pair offered.
REQ-005: in_ready  output  1  block accepts operands this cycle.
REQ-006: op_a  input  WIDTH  first operand.
REQ-007: op_b  input  WIDTH  second operand.
REQ-008: cin_in  input  1  initial carry-in.
REQ-009: A0, A1  output  1 each  bit 0 and bit 1 of current op_a digit, to the external 2-bit ripple adder.
REQ-010: B0, B1  output  1 each  bit 0 and bit 1 of current op_b digit, to the adder.
REQ-011: Cin  output  1  carry into the adder for the current digit.
REQ-012: S0, S1, Cout  input  1 each  combinational sum bits and carry-out returned by the adder in the same cycle.
REQ-013: out_valid  output  1  result available.
REQ-014: out_ready  input  1  consumer takes result this cycle.
REQ-015: sum  output  WIDTH  registered result.
REQ-016: cout_out  output  1  registered final carry.

Function
REQ-017: FSM states IDLE, RUN, DONE; counter of ceil(log2(WIDTH/2+1)) bits counts digits processed.
REQ-018: IDLE: in_ready=1, out_valid=0; on edge with in_valid=1, latch op_a, op_b into shift registers, carry register <= cin_in, counter <= 0, go RUN.
REQ-019: RUN: A0/A1 = a_shift[0]/[1], B0/B1 = b_shift[0]/[1], Cin = carry register; all driven from registers only.
REQ-020: RUN, each edge: {S1,S0} shifted into sum register at bits [WIDTH-1:WIDTH-2] (sum shifts right by 2), carry register <= Cout, a_shift and b_shift shift right by 2, counter increments.
REQ-021: On the edge where counter reaches WIDTH/2, go DONE; sum = full WIDTH-bit result with digit 0 in bits [1:0], cout_out = final Cout.
REQ-022: Latency: acceptance edge E0; out_valid rises after edge E(WIDTH/2) (4 edges for WIDTH=8); one operand pair in flight at a time.
REQ-023: DONE: out_valid=1; sum and cout_out held stable until out_ready=1 sampled on an edge, then go IDLE.
REQ-024: in_ready=0 in RUN and DONE; in_valid there is ignored and no operand register changes.
REQ-025: No combinational in_ready/out_ready bypass; next operand accepted no earlier than the edge after return to IDLE.
REQ-026: A0, A1, B0, B1, Cin SHALL be 0 in IDLE and DONE.
REQ-027: Arithmetic is modulo 2^WIDTH with carry-out in cout_out: {cout_out,sum} = op_a + op_b + cin_in.
REQ-028: sum and cout_out retain last result in IDLE until next RUN begins overwriting.

Reset
REQ-029: rst_n=0 SHALL immediately force state IDLE, counter 0, shift, sum and carry registers 0, cout_out 0, out_valid 0, adder-facing outputs 0.
REQ-030: Reset during RUN or DONE aborts the operation; no result is presented afterwards.
REQ-031: in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Verification (WIDTH=8, bench models adder as {Cout,S1,S0}=A+B+Cin)
REQ-032: 0x00+0x00, cin 0 -> sum 0x00, cout_out 0, out_valid after exactly 4 edges post-acceptance.
REQ-033: 0xFF+0x01, cin 0 -> sum 0x00, cout_out 1; Cin to adder observed 1 in digits 1..3.
REQ-034: 0xA5+0x5A, cin 1 -> sum 0x00, cout_out 1; 0x7F+0x80, cin 0 -> sum 0xFF, cout_out 0.
REQ-035: Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> sum/cout_out stable, in_ready 0, new operands not taken; out_ready=1 -> IDLE, then new pair accepted.
REQ-036: rst_n pulsed low at digit 2 of RUN -> all outputs 0 at once, in_ready 1 after release, next operation correct.
REQ-037: Random 1000 pairs plus cin, with random out_ready stalls -> every result equals op_a+op_b+cin_in.
